// File: rtl/mulu_seq_xy.sv
// Radix-2 shift-add sequential multiplier with valid/ready operand and result handshakes.
// Optional two's-complement mode; the product is held until the consumer takes it.
module mulu_seq_xy #(
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int HAS_SIGNED = 1,
    localparam int P_WIDTH   = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               signed_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [P_WIDTH-1:0] p,
    output logic               s
);

    localparam int CNT_W = $clog2(Y_WIDTH + 1);
    localparam logic [X_WIDTH-1:0] X_ONE     = 1;
    localparam logic [Y_WIDTH-1:0] Y_ONE     = 1;
    localparam logic [P_WIDTH-1:0] P_ONE     = 1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(Y_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH:0]   acc_q, acc_d;
    logic [X_WIDTH-1:0] xMag_q, xMag_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] p_q, p_d;
    logic               s_q, s_d;

    logic               signedMode;
    logic [X_WIDTH-1:0] xMag;
    logic [Y_WIDTH-1:0] yMag;
    logic [X_WIDTH:0]   upperSum;
    logic [P_WIDTH:0]   stepAcc;
    logic [P_WIDTH-1:0] prodMag;
    logic [P_WIDTH-1:0] prodFix;

    assign signedMode = (HAS_SIGNED != 0) && signed_en;
    assign xMag = (signedMode && x[X_WIDTH-1]) ? (~x + X_ONE) : x;
    assign yMag = (signedMode && y[Y_WIDTH-1]) ? (~y + Y_ONE) : y;

    // Multiplier bits sit in the low end of the accumulator and shift out as partial sums shift in.
    assign upperSum = acc_q[P_WIDTH:Y_WIDTH] + (acc_q[0] ? {1'b0, xMag_q} : '0);
    assign stepAcc  = {1'b0, upperSum, acc_q[Y_WIDTH-1:1]};
    assign prodMag  = stepAcc[P_WIDTH-1:0];
    assign prodFix  = neg_q ? (~prodMag + P_ONE) : prodMag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            xMag_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            xMag_q  <= xMag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        xMag_d  = xMag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = {{(X_WIDTH + 1){1'b0}}, yMag};
                    xMag_d  = xMag;
                    neg_d   = signedMode && (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = stepAcc;
                cnt_d = cnt_q + CNT_ONE;
                // The last shift-add edge also applies the sign and publishes the result.
                if (cnt_q == CNT_LAST) begin
                    p_d     = prodFix;
                    s_d     = neg_q && (prodFix != '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p         = p_q;
    assign s         = s_q;

endmodule

// File: tb/tb_mulu_seq_xy.sv
// Directed and randomised checks of mulu_seq_xy in 3x3 signed, 3x3 unsigned-only and 8x5 signed builds.
module tb_mulu_seq_xy;

    logic clk;
    logic rstN;

    logic       aInValid, aInReady, aSe, aOutValid, aOutReady, aS;
    logic [2:0] aX, aY;
    logic [5:0] aP;
    logic       cInReady, cOutValid, cS;
    logic [5:0] cP;

    logic        bInValid, bInReady, bSe, bOutValid, bOutReady, bS;
    logic [7:0]  bX;
    logic [4:0]  bY;
    logic [12:0] bP;

    int checks = 0;
    int errors = 0;

    mulu_seq_xy #(.X_WIDTH(3), .Y_WIDTH(3), .HAS_SIGNED(1)) dutA (
        .clk(clk), .rst_n(rstN), .in_valid(aInValid), .in_ready(aInReady),
        .x(aX), .y(aY), .signed_en(aSe), .out_valid(aOutValid),
        .out_ready(aOutReady), .p(aP), .s(aS)
    );

    // Unsigned-only build shares the 3x3 stimulus so signed_en must be ignored.
    mulu_seq_xy #(.X_WIDTH(3), .Y_WIDTH(3), .HAS_SIGNED(0)) dutC (
        .clk(clk), .rst_n(rstN), .in_valid(aInValid), .in_ready(cInReady),
        .x(aX), .y(aY), .signed_en(aSe), .out_valid(cOutValid),
        .out_ready(aOutReady), .p(cP), .s(cS)
    );

    mulu_seq_xy #(.X_WIDTH(8), .Y_WIDTH(5), .HAS_SIGNED(1)) dutB (
        .clk(clk), .rst_n(rstN), .in_valid(bInValid), .in_ready(bInReady),
        .x(bX), .y(bY), .signed_en(bSe), .out_valid(bOutValid),
        .out_ready(bOutReady), .p(bP), .s(bS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 3x3 operation through both 3x3 builds, taken as soon as it is valid.
    task automatic applyStimulus(input string tag, input logic [2:0] xv, input logic [2:0] yv,
                                 input logic se, input logic [5:0] expP, input logic expS,
                                 input logic [5:0] expPc);
        int lat;
        @(negedge clk);
        checkOutput({tag, "_inready"}, 32'(aInReady), 32'd1);
        aX = xv; aY = yv; aSe = se; aInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aInValid = 1'b0;
        lat = 0;
        while (!aOutValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
        checkOutput({tag, "_p"}, 32'(aP), 32'(expP));
        checkOutput({tag, "_s"}, 32'(aS), 32'(expS));
        checkOutput({tag, "_unsignedonly_p"}, 32'(cP), 32'(expPc));
        checkOutput({tag, "_unsignedonly_s"}, 32'(cS), 32'd0);
        aOutReady = 1'b1;
        @(negedge clk);
        aOutReady = 1'b0;
        checkOutput({tag, "_outvalid_drop"}, 32'(aOutValid), 32'd0);
        checkOutput({tag, "_inready_back"}, 32'(aInReady), 32'd1);
    endtask

    task automatic runWide(input string tag, input logic [7:0] xv, input logic [4:0] yv,
                           input logic se, input logic [12:0] expP, input logic expS,
                           input logic checkLat);
        int lat;
        @(negedge clk);
        bX = xv; bY = yv; bSe = se; bInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bInValid = 1'b0;
        lat = 0;
        while (!bOutValid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (checkLat) checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
        checkOutput({tag, "_p"}, 32'(bP), 32'(expP));
        checkOutput({tag, "_s"}, 32'(bS), 32'(expS));
        bOutReady = 1'b1;
        @(negedge clk);
        bOutReady = 1'b0;
    endtask

    initial begin
        int seen;
        aInValid = 0; aOutReady = 0; aSe = 0; aX = 0; aY = 0;
        bInValid = 0; bOutReady = 0; bSe = 0; bX = 0; bY = 0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_inready", 32'(aInReady), 32'd1);
        checkOutput("reset_outvalid", 32'(aOutValid), 32'd0);
        checkOutput("reset_p", 32'(aP), 32'd0);
        checkOutput("reset_s", 32'(aS), 32'd0);
        rstN = 1'b1;

        applyStimulus("unsigned_7x7", 3'd7, 3'd7, 1'b0, 6'd49, 1'b0, 6'd49);
        applyStimulus("signed_m1x3", 3'b111, 3'b011, 1'b1, 6'b111101, 1'b1, 6'd21);
        applyStimulus("signed_m4xm4", 3'b100, 3'b100, 1'b1, 6'd16, 1'b0, 6'd16);
        applyStimulus("signed_0xm3", 3'b000, 3'b101, 1'b1, 6'd0, 1'b0, 6'd0);
        applyStimulus("signed_m1xm1", 3'b111, 3'b111, 1'b1, 6'd1, 1'b0, 6'd49);
        applyStimulus("signed_3xm2", 3'b011, 3'b110, 1'b1, 6'd58, 1'b1, 6'd18);

        // Backpressure: result parked for 10 cycles while a new request is offered.
        @(negedge clk);
        aX = 3'd5; aY = 3'd6; aSe = 1'b0; aInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aInValid = 1'b0;
        repeat (3) @(negedge clk);
        aX = 3'd1; aY = 3'd1; aInValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_outvalid", 32'(aOutValid), 32'd1);
            checkOutput("bp_p", 32'(aP), 32'd30);
            checkOutput("bp_inready", 32'(aInReady), 32'd0);
            @(negedge clk);
        end
        aInValid = 1'b0;
        aOutReady = 1'b1;
        @(negedge clk);
        aOutReady = 1'b0;
        checkOutput("bp_inready_after", 32'(aInReady), 32'd1);
        checkOutput("bp_outvalid_after", 32'(aOutValid), 32'd0);
        checkOutput("bp_p_held", 32'(aP), 32'd30);

        // Reset one cycle into RUN must discard the operation.
        @(negedge clk);
        aX = 3'd7; aY = 3'd7; aSe = 1'b0; aInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aInValid = 1'b0;
        rstN = 1'b0;
        #1;
        checkOutput("rst_run_inready", 32'(aInReady), 32'd1);
        checkOutput("rst_run_outvalid", 32'(aOutValid), 32'd0);
        checkOutput("rst_run_p", 32'(aP), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (aOutValid) seen = 1;
        end
        checkOutput("rst_run_no_stale", 32'(seen), 32'd0);
        applyStimulus("after_reset_2x3", 3'd2, 3'd3, 1'b0, 6'd6, 1'b0, 6'd6);

        runWide("wide_255x31", 8'd255, 5'd31, 1'b0, 13'd7905, 1'b0, 1'b1);
        runWide("wide_m128xm16", 8'h80, 5'h10, 1'b1, 13'd2048, 1'b0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            logic [7:0] xr;
            logic [4:0] yr;
            logic se;
            int xv, yv, prod;
            xr = 8'($urandom_range(0, 255));
            yr = 5'($urandom_range(0, 31));
            se = 1'($urandom_range(0, 1));
            xv = int'(xr);
            yv = int'(yr);
            if (se) begin
                if (xr[7]) xv = xv - 256;
                if (yr[4]) yv = yv - 32;
            end
            prod = xv * yv;
            runWide("wide_rand", xr, yr, se, prod[12:0], prod < 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
